// File: rtl/apb_timer_top.sv
// APB slave wrapping a 64-bit free-running system timer with 2^N prescaler,
// 64-bit compare, maskable level interrupt and debug-mode halt.
module apb_timer_top (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  input  logic [3:0]  tim_pstrb,
  output logic [31:0] tim_prdata,
  output logic        tim_pready,
  output logic        tim_pslverr,
  output logic        tim_int,
  input  logic        dbg_mode
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned PRE_W  = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [DIV_W-1:0] DIV_MAX = 4'd8;
  localparam logic [DIV_W-1:0] DIV_RST = 4'd1;

  localparam logic [IDX_W-1:0] IDX_TCR   = 3'd0;
  localparam logic [IDX_W-1:0] IDX_TDR0  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_TDR1  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_TCMP0 = 3'd3;
  localparam logic [IDX_W-1:0] IDX_TCMP1 = 3'd4;
  localparam logic [IDX_W-1:0] IDX_TIER  = 3'd5;
  localparam logic [IDX_W-1:0] IDX_TISR  = 3'd6;
  localparam logic [IDX_W-1:0] IDX_THCSR = 3'd7;

  // The reset pin keeps its legacy _n name but is active-high.
  logic rst;
  assign rst = sys_rst_n;

  logic              timer_en;
  logic              div_en;
  logic [DIV_W-1:0]  div_val;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cmp;
  logic              int_en;
  logic              int_st;
  logic              halt_req;
  logic [PRE_W-1:0]  presc;

  logic              access;
  logic              wr_acc;
  logic              mapped;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tcr_val;

  logic we_tcr, we_tdr0, we_tdr1, we_tcmp0, we_tcmp1, we_tier, we_tisr, we_thcsr;
  logic              tcr_sel;
  logic              tcr_err;
  logic              new_en;
  logic              new_div_en;
  logic [DIV_W-1:0]  new_div_val;
  logic              disable_evt;
  logic              halt_ack;
  logic              count_en;
  logic [PRE_W-1:0]  presc_top;
  logic              tick;
  logic              match;
  logic              int_clr;
  logic              unused_addr;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [DATA_W-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  // Bus decode
  assign access      = tim_psel & tim_penable;
  assign wr_acc      = access & tim_pwrite;
  assign mapped      = (tim_paddr[11:5] == 7'd0);
  assign idx         = tim_paddr[4:2];
  assign unused_addr = ^tim_paddr[1:0];
  assign wmask       = {{8{tim_pstrb[3]}}, {8{tim_pstrb[2]}},
                        {8{tim_pstrb[1]}}, {8{tim_pstrb[0]}}};

  assign tcr_sel  = wr_acc & mapped & (idx == IDX_TCR);
  assign we_tdr0  = wr_acc & mapped & (idx == IDX_TDR0);
  assign we_tdr1  = wr_acc & mapped & (idx == IDX_TDR1);
  assign we_tcmp0 = wr_acc & mapped & (idx == IDX_TCMP0);
  assign we_tcmp1 = wr_acc & mapped & (idx == IDX_TCMP1);
  assign we_tier  = wr_acc & mapped & (idx == IDX_TIER);
  assign we_tisr  = wr_acc & mapped & (idx == IDX_TISR);
  assign we_thcsr = wr_acc & mapped & (idx == IDX_THCSR);

  // Candidate TCR fields after byte-lane merge; the whole write is rejected on error.
  assign new_en      = tim_pstrb[0] ? tim_pwdata[0]    : timer_en;
  assign new_div_en  = tim_pstrb[0] ? tim_pwdata[1]    : div_en;
  assign new_div_val = tim_pstrb[1] ? tim_pwdata[11:8] : div_val;

  assign tcr_err = tcr_sel &
                   ((new_div_val > DIV_MAX) |
                    (timer_en & ((new_div_en != div_en) | (new_div_val != div_val))));
  assign we_tcr      = tcr_sel & ~tcr_err;
  assign disable_evt = we_tcr & timer_en & ~new_en;

  assign tcr_val = {20'd0, div_val, 6'd0, div_en, timer_en};

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= DIV_RST;
    end else if (we_tcr) begin
      timer_en <= new_en;
      div_en   <= new_div_en;
      div_val  <= new_div_val;
    end
  end

  // Prescaler: tick fires on the last cycle of each 2^div_val window
  assign halt_ack  = halt_req & dbg_mode;
  assign count_en  = timer_en & ~halt_ack;
  assign presc_top = PRE_W'((9'd1 << div_val) - 9'd1);
  assign tick      = count_en & (~div_en | (presc == presc_top));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      presc <= '0;
    end else if (~count_en | disable_evt | tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Main counter: disable clears, software writes override the increment
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (disable_evt) begin
      cnt <= '0;
    end else if (we_tdr0) begin
      cnt[31:0] <= lane_merge(cnt[31:0], tim_pwdata, wmask);
    end else if (we_tdr1) begin
      cnt[63:32] <= lane_merge(cnt[63:32], tim_pwdata, wmask);
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cmp <= '1;
    end else if (we_tcmp0) begin
      cmp[31:0] <= lane_merge(cmp[31:0], tim_pwdata, wmask);
    end else if (we_tcmp1) begin
      cmp[63:32] <= lane_merge(cmp[63:32], tim_pwdata, wmask);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      int_en   <= 1'b0;
      halt_req <= 1'b0;
    end else begin
      if (we_tier && tim_pstrb[0]) begin
        int_en <= tim_pwdata[0];
      end
      if (we_thcsr && tim_pstrb[0]) begin
        halt_req <= tim_pwdata[0];
      end
    end
  end

  // Compare match sets the status; a set wins over a same-cycle W1C
  assign match   = (cnt == cmp);
  assign int_clr = we_tisr & tim_pstrb[0] & tim_pwdata[0];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      int_st <= 1'b0;
    end else if (match) begin
      int_st <= 1'b1;
    end else if (int_clr) begin
      int_st <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (mapped) begin
      case (idx)
        IDX_TCR:   rd_data = tcr_val;
        IDX_TDR0:  rd_data = cnt[31:0];
        IDX_TDR1:  rd_data = cnt[63:32];
        IDX_TCMP0: rd_data = cmp[31:0];
        IDX_TCMP1: rd_data = cmp[63:32];
        IDX_TIER:  rd_data = {31'd0, int_en};
        IDX_TISR:  rd_data = {31'd0, int_st};
        IDX_THCSR: rd_data = {30'd0, halt_ack, halt_req};
        default:   rd_data = '0;
      endcase
    end
  end

  // Zero-wait-state completion: response is combinational in the access cycle
  assign tim_pready  = access & ~rst;
  assign tim_prdata  = tim_pready ? rd_data : '0;
  assign tim_pslverr = tcr_err & ~rst;
  assign tim_int     = int_en & int_st;

endmodule

// File: tb/tb_apb_timer_top.sv
// Randomised bench for apb_timer_top against a behavioural timer model,
// plus directed register and counting scenarios.
module tb_apb_timer_top;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr, tint;
  logic        dbg_mode;

  apb_timer_top dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tim_psel    (psel),
    .tim_penable (penable),
    .tim_pwrite  (pwrite),
    .tim_paddr   (paddr),
    .tim_pwdata  (pwdata),
    .tim_pstrb   (pstrb),
    .tim_prdata  (prdata),
    .tim_pready  (pready),
    .tim_pslverr (pslverr),
    .tim_int     (tint),
    .dbg_mode    (dbg_mode)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rd;
  logic        last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model state
  bit          m_en, m_div_en, m_ie, m_ist, m_hreq;
  int          m_div_val;
  logic [63:0] m_cnt, m_cmp;
  int          m_pre;

  task automatic model_reset();
    m_en = 0; m_div_en = 0; m_div_val = 1;
    m_cnt = 64'd0; m_cmp = '1;
    m_ie = 0; m_ist = 0; m_hreq = 0; m_pre = 0;
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_tcr();
    return {20'd0, 4'(m_div_val), 6'd0, m_div_en, m_en};
  endfunction

  function automatic bit m_tcr_err(input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] t;
    t = merge32(m_tcr(), wd, s);
    return (int'(t[11:8]) > 8) ||
           (m_en && ((t[1] != m_div_en) || (int'(t[11:8]) != m_div_val)));
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a[11:5] != 7'd0) return 32'h0;
    case (a[4:2])
      3'd0: return m_tcr();
      3'd1: return m_cnt[31:0];
      3'd2: return m_cnt[63:32];
      3'd3: return m_cmp[31:0];
      3'd4: return m_cmp[63:32];
      3'd5: return {31'd0, m_ie};
      3'd6: return {31'd0, m_ist};
      default: return {30'd0, m_hreq && dbg_mode, m_hreq};
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    bit acc, wr, hit, counting, match, clr, ne;
    logic [63:0] nc;
    logic [31:0] t;
    int np, period;
    if (sys_rst_n) begin
      model_reset();
      return;
    end
    acc = psel && penable;
    wr = acc && pwrite;
    hit = wr && (paddr[11:5] == 7'd0);
    counting = m_en && !(m_hreq && dbg_mode);
    match = (m_cnt == m_cmp);
    clr = 0;
    nc = m_cnt;
    np = 0;
    if (counting) begin
      period = m_div_en ? (1 << m_div_val) : 1;
      np = m_pre + 1;
      if (np >= period) begin
        np = 0;
        nc = m_cnt + 64'd1;
      end
    end
    if (hit) begin
      case (paddr[4:2])
        3'd0: if (!m_tcr_err(pwdata, pstrb)) begin
          t = merge32(m_tcr(), pwdata, pstrb);
          ne = t[0];
          if (m_en && !ne) begin nc = 64'd0; np = 0; end
          m_en = ne; m_div_en = t[1]; m_div_val = int'(t[11:8]);
        end
        3'd1: nc = {m_cnt[63:32], merge32(m_cnt[31:0], pwdata, pstrb)};
        3'd2: nc = {merge32(m_cnt[63:32], pwdata, pstrb), m_cnt[31:0]};
        3'd3: m_cmp[31:0]  = merge32(m_cmp[31:0], pwdata, pstrb);
        3'd4: m_cmp[63:32] = merge32(m_cmp[63:32], pwdata, pstrb);
        3'd5: if (pstrb[0]) m_ie = pwdata[0];
        3'd6: clr = pstrb[0] && pwdata[0];
        default: if (pstrb[0]) m_hreq = pwdata[0];
      endcase
    end
    if (match) m_ist = 1;
    else if (clr) m_ist = 0;
    m_cnt = nc;
    m_pre = np;
  endtask

  // One clock: check combinational outputs mid-cycle, then step the model at the edge
  task automatic cycle();
    bit acc;
    #1;
    acc = psel && penable && !sys_rst_n;
    check("pready", pready, acc);
    check("pslverr", pslverr,
          acc && pwrite && (paddr[11:5] == 7'd0) && (paddr[4:2] == 3'd0) &&
          m_tcr_err(pwdata, pstrb));
    if (!(acc && pwrite)) check("prdata", prdata, acc ? m_read(paddr) : 32'h0);
    check("tim_int", tint, m_ie && m_ist);
    last_rd = prdata;
    last_err = pslverr;
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    psel = 0; penable = 0;
    repeat (n) cycle();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d; pstrb = s;
    cycle();
    penable = 1;
    cycle();
    psel = 0; penable = 0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    psel = 1; penable = 0; pwrite = 0; paddr = a; pstrb = 4'h0;
    cycle();
    penable = 1;
    cycle();
    d = last_rd;
    psel = 0; penable = 0;
  endtask

  logic [31:0] rd, a0, b0, c0;
  logic [31:0] rst_vals [8];
  bit got;

  initial begin
    rst_vals = '{32'h100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    dbg_mode = 0; sys_rst_n = 1;
    model_reset();
    @(negedge sys_clk);
    idle(2);
    psel = 1; penable = 1;
    cycle();
    psel = 0; penable = 0;
    sys_rst_n = 0;
    idle(1);

    // Reset values of every register
    for (int i = 0; i < 8; i++) begin
      apb_read(12'(i * 4), rd);
      check($sformatf("rst_reg%0d", i), rd, rst_vals[i]);
    end

    // Compare match raises the interrupt, W1C clears it
    apb_write(12'h00C, 32'd5, 4'hF);
    apb_write(12'h010, 32'd0, 4'hF);
    apb_write(12'h014, 32'd1, 4'hF);
    apb_write(12'h000, 32'h1, 4'hF);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      idle(1);
      got = tint;
    end
    check("t2_int_rise", got, 1);
    apb_read(12'h018, rd);
    check("t2_tisr", rd, 32'h1);
    apb_write(12'h000, 32'h0, 4'hF);
    apb_write(12'h018, 32'h1, 4'hF);
    idle(1);
    check("t2_int_clear", tint, 0);

    // Divide by 8, then a rejected divider change while running
    apb_write(12'h000, 32'h303, 4'hF);
    check("t3_en_ok", last_err, 0);
    apb_read(12'h004, a0);
    idle(6);
    apb_read(12'h004, b0);
    check("t3_div8", b0 - a0, 32'd1);
    apb_write(12'h000, 32'h403, 4'hF);
    check("t3_err", last_err, 1);
    apb_read(12'h000, rd);
    check("t3_tcr_kept", rd, 32'h303);
    apb_write(12'h000, 32'h302, 4'hF);
    apb_write(12'h000, 32'h100, 4'hF);

    // Out-of-range divider and byte-lane strobes
    apb_write(12'h000, 32'h900, 4'hF);
    check("t4_err", last_err, 1);
    apb_read(12'h000, rd);
    check("t4_tcr_kept", rd, 32'h100);
    apb_write(12'h000, 32'h0000_0F01, 4'b0001);
    check("t4_strb_ok", last_err, 0);
    apb_read(12'h000, rd);
    check("t4_strb_tcr", rd, 32'h101);
    apb_write(12'h000, 32'h100, 4'hF);

    // 64-bit wrap, then disable clears the counter
    apb_write(12'h004, 32'hFFFF_FFFE, 4'hF);
    apb_write(12'h008, 32'hFFFF_FFFF, 4'hF);
    apb_write(12'h000, 32'h1, 4'hF);
    apb_read(12'h008, rd);
    check("t5_pre_wrap", rd, 32'hFFFF_FFFF);
    apb_read(12'h008, rd);
    check("t5_wrapped_hi", rd, 32'h0);
    apb_write(12'h000, 32'h0, 4'hF);
    apb_read(12'h004, rd);
    check("t5_clr_lo", rd, 32'h0);
    apb_read(12'h008, rd);
    check("t5_clr_hi", rd, 32'h0);

    // Debug halt freezes the count, release resumes from the frozen value
    apb_write(12'h000, 32'h1, 4'hF);
    idle(3);
    dbg_mode = 1;
    apb_write(12'h01C, 32'h1, 4'hF);
    apb_read(12'h01C, rd);
    check("t6_thcsr_ack", rd, 32'h3);
    apb_read(12'h004, a0);
    idle(4);
    apb_read(12'h004, b0);
    check("t6_frozen", b0, a0);
    dbg_mode = 0;
    apb_read(12'h004, c0);
    check("t6_resume", c0, b0 + 32'd1);
    apb_read(12'h01C, rd);
    check("t6_thcsr_rel", rd, 32'h1);

    // Reset while counting
    sys_rst_n = 1;
    idle(2);
    sys_rst_n = 0;
    apb_read(12'h004, rd);
    check("rst_mid_cnt", rd, 32'h0);
    apb_read(12'h000, rd);
    check("rst_mid_tcr", rd, 32'h100);

    // Randomised traffic against the model
    for (int it = 0; it < 800; it++) begin
      int op, ix;
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0] s;
      op = $urandom_range(0, 9);
      ix = $urandom_range(0, 7);
      a = {($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 127)) : 7'd0,
           3'(ix), 2'($urandom_range(0, 3))};
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (ix)
        0: d = ($urandom_range(0, 1) == 1) ? (m_tcr() ^ 32'h1)
                                           : {20'($urandom), 4'($urandom_range(0, 9)), 8'($urandom)};
        1, 3: d = 32'($urandom_range(0, 60));
        2, 4: d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
        default: d = 32'($urandom);
      endcase
      if (op < 4) apb_write(a, d, s);
      else if (op < 7) apb_read(a, rd);
      else if (op < 9) idle($urandom_range(1, 4));
      else begin
        dbg_mode = ~dbg_mode;
        idle(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
